// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared types and constants for the BRAM-backed FIFO controller.
package bram_fifo_ctrl_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned RD_LATENCY      = 1;

  // Occupancy: RAM (up to DEPTH) + in-flight read + two prefetch entries.
  typedef logic [FIFO_ADDR_WIDTH+1:0] occ_t;

endpackage

// File: rtl/bram_fifo_prefetch.sv
// Two-entry output buffer that hides the RAM read latency from the consumer.
module bram_fifo_prefetch
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            ob_cnt,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid
);

  logic [1:0]            cnt_d;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;

  // Head always holds the oldest entry; tail only used when two are held.
  always_comb begin
    cnt_d  = 2'(ob_cnt + 2'(push) - 2'(pop));
    head_d = head;
    tail_d = tail_q;
    case (ob_cnt)
      2'd0: begin
        if (push) head_d = push_data;
      end
      2'd1: begin
        if (push && pop) head_d = push_data;
        else if (push)   tail_d = push_data;
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_cnt <= 2'd0;
      head   <= '0;
      tail_q <= '0;
      valid  <= 1'b0;
    end else begin
      ob_cnt <= cnt_d;
      head   <= head_d;
      tail_q <= tail_d;
      valid  <= (cnt_d != 2'd0);
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a dual-port BRAM with one-cycle read latency.
// Optional BRAM_FIFO_BYPASS_EN writes into the prefetch buffer directly when it is the only storage in use.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  input  logic                  deq_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH-1:0] mem_addrw,
  output logic [DATA_WIDTH-1:0] mem_di,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addrr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned MW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q;
  logic                  enq_ready_d;
  occ_t                  count_q, count_d;

  logic [1:0]            ob_cnt;
  logic                  enq_fire_c;
  logic                  deq_fire_c;
  logic                  bypass_c;
  logic                  ram_wr_c;
  logic                  issue_c;
  logic                  ob_push_c;
  logic [DATA_WIDTH-1:0] ob_push_data_c;

  assign enq_fire_c = enq_valid & enq_ready;
  assign deq_fire_c = deq_valid & deq_ready;

`ifdef BRAM_FIFO_BYPASS_EN
  // Nothing older in RAM or in flight, so the buffer may take the word directly.
  assign bypass_c = enq_fire_c && (mem_cnt_q == '0) && !rd_inflight_q &&
                    ({1'b0, ob_cnt} < (3'd2 + 3'(deq_fire_c)));
`else
  assign bypass_c = 1'b0;
`endif

  assign ram_wr_c = enq_fire_c & ~bypass_c;

  // Issue only if the buffer still has room once the outstanding read lands.
  assign issue_c = (mem_cnt_q != '0) &&
                   (({1'b0, ob_cnt} + 3'(rd_inflight_q)) < (3'd2 + 3'(deq_fire_c)));

  // Return and bypass are exclusive: bypass requires no read in flight.
  assign ob_push_c      = rd_inflight_q | bypass_c;
  assign ob_push_data_c = rd_inflight_q ? mem_do : enq_data;

  assign mem_wen   = ram_wr_c;
  assign mem_addrw = wptr_q;
  assign mem_di    = enq_data;
  assign mem_ren   = issue_c;
  assign mem_addrr = rptr_q;
  assign count     = (ADDR_WIDTH+2)'(count_q);

  always_comb begin
    wptr_d      = ram_wr_c ? ADDR_WIDTH'(wptr_q + 1'b1) : wptr_q;
    rptr_d      = issue_c  ? ADDR_WIDTH'(rptr_q + 1'b1) : rptr_q;
    mem_cnt_d   = MW'(mem_cnt_q + MW'(ram_wr_c) - MW'(issue_c));
    enq_ready_d = (mem_cnt_d < MW'(DEPTH));
    count_d     = occ_t'(count_q + occ_t'(enq_fire_c) - occ_t'(deq_fire_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      enq_ready     <= 1'b0;
      count_q       <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= issue_c;
      enq_ready     <= enq_ready_d;
      count_q       <= count_d;
    end
  end

  bram_fifo_prefetch #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prefetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ob_push_c),
    .push_data(ob_push_data_c),
    .pop      (deq_fire_c),
    .ob_cnt   (ob_cnt),
    .head     (deq_data),
    .valid    (deq_valid)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a BRAM model and a queue-based reference.
module tb_bram_fifo_ctrl;
  import bram_fifo_ctrl_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          enq_valid;
  logic [DW-1:0] enq_data;
  logic          enq_ready;
  logic          deq_valid;
  logic [DW-1:0] deq_data;
  logic          deq_ready;
  logic [AW+1:0] count;
  logic [AW-1:0] mem_addrw;
  logic [DW-1:0] mem_di;
  logic          mem_wen;
  logic [AW-1:0] mem_addrr;
  logic          mem_ren;
  logic [DW-1:0] mem_do;

  int checks   = 0;
  int failures = 0;

  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_valid(enq_valid),
    .enq_data (enq_data),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid),
    .deq_data (deq_data),
    .deq_ready(deq_ready),
    .count    (count),
    .mem_addrw(mem_addrw),
    .mem_di   (mem_di),
    .mem_wen  (mem_wen),
    .mem_addrr(mem_addrr),
    .mem_ren  (mem_ren),
    .mem_do   (mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM: synchronous write, registered read address, one-cycle latency.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] mem_do_q;
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addrw] <= mem_di;
    if (mem_ren) mem_do_q <= ram[mem_addrr];
  end
  assign mem_do = mem_do_q;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a plain queue of accepted words plus RAM write/read tallies.
  logic [DW-1:0] model[$];
  int unsigned   wr_n = 0;
  int unsigned   rd_n = 0;
  int            deq_total = 0;
  logic          armed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      model.delete();
      wr_n = 0;
      rd_n = 0;
    end else begin
      chk("count_vs_model", 64'(count), 64'(model.size()));
      if (deq_valid) begin
        if (model.size() == 0) chk("deq_valid_on_empty", 64'(1), 64'(0));
        else                   chk("deq_data_order", 64'(deq_data), 64'(model[0]));
      end
      if (armed && model.size() < DEPTH) chk("enq_ready_space", 64'(enq_ready), 64'(1));
      if (model.size() == DEPTH + 2)     chk("enq_ready_full", 64'(enq_ready), 64'(0));
`ifndef BRAM_FIFO_BYPASS_EN
      chk("wen_every_enq", 64'(mem_wen), 64'(enq_valid & enq_ready));
`endif
      if (mem_wen) begin
        chk("wen_needs_fire", 64'(enq_valid & enq_ready), 64'(1));
        chk("write_addr", 64'(mem_addrw), 64'(wr_n % DEPTH));
        chk("write_data", 64'(mem_di), 64'(enq_data));
      end
      if (mem_ren) begin
        chk("ren_ram_nonempty", 64'(rd_n < wr_n), 64'(1));
        chk("read_addr", 64'(mem_addrr), 64'(rd_n % DEPTH));
      end
      if (mem_wen) wr_n++;
      if (mem_ren) rd_n++;
      if (deq_valid && deq_ready && model.size() > 0) begin
        void'(model.pop_front());
        deq_total++;
      end
      if (enq_valid && enq_ready) model.push_back(enq_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void check_reset();
    chk("rst_deq_valid", 64'(deq_valid), 64'(0));
    chk("rst_enq_ready", 64'(enq_ready), 64'(0));
    chk("rst_mem_wen",   64'(mem_wen),   64'(0));
    chk("rst_mem_ren",   64'(mem_ren),   64'(0));
    chk("rst_count",     64'(count),     64'(0));
    chk("rst_deq_data",  64'(deq_data),  64'(0));
  endfunction

  task automatic drain(input string name);
    int n = 0;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    while ((count != '0 || deq_valid) && n < 200) begin
      step();
      n++;
    end
    chk(name, 64'(n < 200), 64'(1));
    deq_ready = 1'b0;
  endtask

  typedef struct {
    logic          ev;
    logic [DW-1:0] ed;
    logic          dr;
    logic          xdv;
    logic [DW-1:0] xdd;
    int unsigned   xcnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v, acc, cyc, d0, n;

`ifdef BRAM_FIFO_BYPASS_EN
    vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0};
`else
    vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 1};
`endif
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0};

    rst_n = 1'b0;
    enq_valid = 1'b0;
    enq_data = '0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    step();
    chk("enq_ready_rise", 64'(enq_ready), 64'(1));

    // Single-word latency from an empty FIFO.
    for (int i = 0; i < 6; i++) begin
      enq_valid = vecs[i].ev;
      enq_data  = vecs[i].ed;
      deq_ready = vecs[i].dr;
      step();
      chk($sformatf("vec%0d_deq_valid", i), 64'(deq_valid), 64'(vecs[i].xdv));
      if (vecs[i].xdv) chk($sformatf("vec%0d_deq_data", i), 64'(deq_data), 64'(vecs[i].xdd));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].xcnt));
    end

    // Fill with the consumer stalled: capacity is DEPTH+2.
    deq_ready = 1'b0;
    v = 0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      enq_valid = (v < 20);
      enq_data  = DW'(v);
      if (enq_valid && enq_ready) begin
        acc++;
        step();
        v++;
      end else begin
        step();
      end
    end
    enq_valid = 1'b0;
    chk("fill_accepted", 64'(acc), 64'(DEPTH + 2));
    chk("fill_count", 64'(count), 64'(DEPTH + 2));
    chk("fill_enq_ready", 64'(enq_ready), 64'(0));
    d0 = deq_total;
    drain("fill_drain_timeout");
    chk("fill_drained", 64'(deq_total - d0), 64'(DEPTH + 2));

    // Continuous streaming of 1000 words with the consumer always ready.
    v = 0;
    cyc = 0;
    d0 = deq_total;
    deq_ready = 1'b1;
    while (v < 1000 && cyc < 1100) begin
      enq_valid = 1'b1;
      enq_data  = DW'(v);
      if (enq_ready) v++;
      step();
      cyc++;
    end
    chk("stream_cycles", 64'(cyc), 64'(1000));
    chk("stream_deq_rate", 64'((deq_total - d0) >= 997), 64'(1));
    drain("stream_drain_timeout");
    chk("stream_total", 64'(deq_total - d0), 64'(1000));

    // Random valid/ready traffic.
    for (int c = 0; c < 10000; c++) begin
      enq_valid = ($urandom_range(0, 99) < 50);
      enq_data  = $urandom;
      deq_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    drain("random_drain_timeout");

    // Reset with 10 entries held and a read in flight.
    deq_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      enq_valid = 1'b1;
      enq_data  = 32'hC000_0000 | DW'(i);
      step();
    end
    enq_valid = 1'b0;
    repeat (6) step();
    chk("pre_rst_count11", 64'(count), 64'(11));
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("pre_rst_count10", 64'(count), 64'(10));
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_enq_ready", 64'(enq_ready), 64'(1));
    chk("post_rst_count", 64'(count), 64'(0));
    chk("post_rst_deq_valid", 64'(deq_valid), 64'(0));
    enq_valid = 1'b1;
    enq_data  = 32'h1;
    step();
    enq_valid = 1'b0;
    n = 0;
    while (!deq_valid && n < 6) begin
      step();
      n++;
    end
    chk("post_rst_deq_arrives", 64'(deq_valid), 64'(1));
    chk("post_rst_deq_data", 64'(deq_data), 64'(32'h1));
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("post_rst_final_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
